// File: rtl/noc_eject_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : noc_eject_unit_if
// Purpose  : Router-side and core-side flit handshake bundle for the
//            ejection endpoint.
// Revision : 1.0  initial release
// ============================================================================
interface noc_eject_unit_if #(
  parameter int DW = 64
);
  // router local output side
  logic [DW-1:0] data_i;
  logic          valid_i;
  logic          ready_o;
  logic          credit_upd;
  // core side
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_sop;
  logic          out_eop;

  modport slave (
    input  data_i, valid_i, out_ready,
    output ready_o, credit_upd, out_data, out_valid, out_sop, out_eop
  );

  modport master (
    output data_i, valid_i, out_ready,
    input  ready_o, credit_upd, out_data, out_valid, out_sop, out_eop
  );
endinterface
`default_nettype wire

// File: rtl/noc_eject_unit.sv
`default_nettype none
// ============================================================================
// Module   : noc_eject_unit
// Purpose  : Router local-port ejection endpoint: credit-matched flit buffer,
//            packet framing check, sop/eop markers and credit return.
// Revision : 1.0  initial release
// ============================================================================
module noc_eject_unit #(
  parameter int DW        = 64,
  parameter int BUF_DEPTH = 4,
  parameter int CNT_W     = 16
) (
  input  wire logic             clk,
  input  wire logic             rst,
  noc_eject_unit_if.slave       bus,
  output logic                  pkt_err,
  output logic                  overflow,
  output logic [CNT_W-1:0]      pkt_cnt
);

  localparam int              c_AW        = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam logic [c_AW:0]   c_PTR_ONE   = (c_AW+1)'(1);
  localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
  localparam logic [1:0]      c_FT_BODY   = 2'b00;
  localparam logic [1:0]      c_FT_HEAD   = 2'b01;
  localparam logic [1:0]      c_FT_TAIL   = 2'b10;
  localparam logic [1:0]      c_FT_SINGLE = 2'b11;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_IN_PKT = 1'b1
  } state_e;

  logic [DW-1:0]   mem_q [BUF_DEPTH];
  logic [c_AW:0]   wr_ptr_q, wr_ptr_d;
  logic [c_AW:0]   rd_ptr_q, rd_ptr_d;
  state_e          state_q, state_d;
  logic            credit_q, credit_d;
  logic            pkt_err_q, pkt_err_d;
  logic            overflow_q, overflow_d;
  logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;

  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic [DW-1:0]   w_head;
  logic [1:0]      w_type;
  logic            w_sop;
  logic            w_eop;
  logic            w_err;
  state_e          w_state_nxt;

  // Extra pointer MSB distinguishes full from empty when the low bits match.
  assign w_full  = (wr_ptr_q[c_AW] != rd_ptr_q[c_AW]) &&
                   (wr_ptr_q[c_AW-1:0] == rd_ptr_q[c_AW-1:0]);
  assign w_empty = (wr_ptr_q == rd_ptr_q);
  assign w_push  = bus.valid_i && !w_full;
  assign w_pop   = !w_empty && bus.out_ready;
  assign w_head  = mem_q[rd_ptr_q[c_AW-1:0]];
  assign w_type  = w_head[DW-1:DW-2];

  // Storage has no reset: entries are only observed between push and pop.
  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q[c_AW-1:0]] <= bus.data_i;
    end
  end

  // Framing decode; markers are gated with !empty so stale entries never show.
  always_comb begin
    w_sop       = 1'b0;
    w_eop       = 1'b0;
    w_err       = 1'b0;
    w_state_nxt = state_q;
    if (!w_empty) begin
      unique case (state_q)
        ST_IDLE: begin
          unique case (w_type)
            c_FT_HEAD:   begin w_sop = 1'b1; w_state_nxt = ST_IN_PKT; end
            c_FT_SINGLE: begin w_sop = 1'b1; w_eop = 1'b1; end
            c_FT_BODY:   begin w_err = 1'b1; end
            c_FT_TAIL:   begin w_err = 1'b1; w_eop = 1'b1; end
            default:     ;
          endcase
        end
        ST_IN_PKT: begin
          unique case (w_type)
            c_FT_BODY:   ;
            c_FT_TAIL:   begin w_eop = 1'b1; w_state_nxt = ST_IDLE; end
            c_FT_HEAD:   begin w_err = 1'b1; w_sop = 1'b1; end
            c_FT_SINGLE: begin
              w_err = 1'b1; w_sop = 1'b1; w_eop = 1'b1; w_state_nxt = ST_IDLE;
            end
            default:     ;
          endcase
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    state_d    = state_q;
    credit_d   = w_pop;
    pkt_err_d  = pkt_err_q;
    overflow_d = overflow_q;
    pkt_cnt_d  = pkt_cnt_q;
    if (w_push) begin
      wr_ptr_d = wr_ptr_q + c_PTR_ONE;
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + c_PTR_ONE;
      state_d  = w_state_nxt;
      if (w_err) begin
        pkt_err_d = 1'b1;
      end
      if (w_eop) begin
        pkt_cnt_d = pkt_cnt_q + c_CNT_ONE;
      end
    end
    // A flit offered while full means the router ignored its credit count.
    if (bus.valid_i && w_full) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      state_q    <= ST_IDLE;
      credit_q   <= 1'b0;
      pkt_err_q  <= 1'b0;
      overflow_q <= 1'b0;
      pkt_cnt_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      state_q    <= state_d;
      credit_q   <= credit_d;
      pkt_err_q  <= pkt_err_d;
      overflow_q <= overflow_d;
      pkt_cnt_q  <= pkt_cnt_d;
    end
  end

  assign bus.ready_o    = !w_full;
  assign bus.credit_upd = credit_q;
  assign bus.out_data   = w_head;
  assign bus.out_valid  = !w_empty;
  assign bus.out_sop    = w_sop;
  assign bus.out_eop    = w_eop;
  assign pkt_err        = pkt_err_q;
  assign overflow       = overflow_q;
  assign pkt_cnt        = pkt_cnt_q;

endmodule
`default_nettype wire
